// File: rtl/ifft_8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT with 1/8 scaling.
// One butterfly stage per clock; the frame is loaded bit-reversed and the result is held until consumed.
module ifft_8_seq #(
    parameter int N = 4,
    localparam int W = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_0_r,
    input  logic [W-1:0] in_1_r,
    input  logic [W-1:0] in_2_r,
    input  logic [W-1:0] in_3_r,
    input  logic [W-1:0] in_4_r,
    input  logic [W-1:0] in_5_r,
    input  logic [W-1:0] in_6_r,
    input  logic [W-1:0] in_7_r,
    input  logic [W-1:0] in_0_i,
    input  logic [W-1:0] in_1_i,
    input  logic [W-1:0] in_2_i,
    input  logic [W-1:0] in_3_i,
    input  logic [W-1:0] in_4_i,
    input  logic [W-1:0] in_5_i,
    input  logic [W-1:0] in_6_i,
    input  logic [W-1:0] in_7_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_0_r,
    output logic [W-1:0] out_1_r,
    output logic [W-1:0] out_2_r,
    output logic [W-1:0] out_3_r,
    output logic [W-1:0] out_4_r,
    output logic [W-1:0] out_5_r,
    output logic [W-1:0] out_6_r,
    output logic [W-1:0] out_7_r,
    output logic [W-1:0] out_0_i,
    output logic [W-1:0] out_1_i,
    output logic [W-1:0] out_2_i,
    output logic [W-1:0] out_3_i,
    output logic [W-1:0] out_4_i,
    output logic [W-1:0] out_5_i,
    output logic [W-1:0] out_6_i,
    output logic [W-1:0] out_7_i
);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;

    localparam logic signed [W+9:0] C181 = (W+10)'(181);

    state_t              state;
    logic signed [W-1:0] in_r [8];
    logic signed [W-1:0] in_i [8];
    logic signed [W-1:0] a_r  [8];
    logic signed [W-1:0] a_i  [8];
    logic signed [W-1:0] n_r  [8];
    logic signed [W-1:0] n_i  [8];
    logic signed [W-1:0] o_r  [8];
    logic signed [W-1:0] o_i  [8];
    logic [4*W-1:0]      bf;

    assign in_r = '{in_0_r, in_1_r, in_2_r, in_3_r, in_4_r, in_5_r, in_6_r, in_7_r};
    assign in_i = '{in_0_i, in_1_i, in_2_i, in_3_i, in_4_i, in_5_i, in_6_i, in_7_i};

    assign {out_0_r, out_1_r, out_2_r, out_3_r} = {o_r[0], o_r[1], o_r[2], o_r[3]};
    assign {out_4_r, out_5_r, out_6_r, out_7_r} = {o_r[4], o_r[5], o_r[6], o_r[7]};
    assign {out_0_i, out_1_i, out_2_i, out_3_i} = {o_i[0], o_i[1], o_i[2], o_i[3]};
    assign {out_4_i, out_5_i, out_6_i, out_7_i} = {o_i[4], o_i[5], o_i[6], o_i[7]};

    assign in_ready = (state == IDLE) && !rst;

    function automatic logic [2:0] rev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // (v * 181) >>> 8 evaluated at full product width, result back in W+2 bits
    function automatic logic signed [W+1:0] mul_c(input logic signed [W+1:0] v);
        logic signed [W+9:0] p;
        p = $signed({{8{v[W+1]}}, v}) * C181;
        return (W+2)'(p >>> 8);
    endfunction

    // Scaled butterfly on (A,B) with twiddle W^-e; returns {A'r, A'i, B'r, B'i}
    function automatic logic [4*W-1:0] bfly(input logic signed [W-1:0] ar, ai, br, bi,
                                            input logic [1:0] e);
        logic signed [W+1:0] x, y, xa, ya, tr, ti;
        x  = {{2{br[W-1]}}, br};
        y  = {{2{bi[W-1]}}, bi};
        xa = {{2{ar[W-1]}}, ar};
        ya = {{2{ai[W-1]}}, ai};
        tr = x;
        ti = y;
        case (e)
            2'd1: begin tr = mul_c(x - y);  ti = mul_c(x + y); end
            2'd2: begin tr = -y;            ti = x;            end
            2'd3: begin tr = mul_c(-x - y); ti = mul_c(x - y); end
            default: ;
        endcase
        return {W'((xa + tr) >>> 1), W'((ya + ti) >>> 1),
                W'((xa - tr) >>> 1), W'((ya - ti) >>> 1)};
    endfunction

    always_comb begin
        n_r = a_r;
        n_i = a_i;
        bf  = '0;
        case (state)
            S1: for (int k = 0; k < 8; k += 2) begin
                bf = bfly(a_r[k], a_i[k], a_r[k+1], a_i[k+1], 2'd0);
                {n_r[k], n_i[k], n_r[k+1], n_i[k+1]} = bf;
            end
            S2: for (int k = 0; k < 2; k++) begin
                bf = bfly(a_r[k], a_i[k], a_r[k+2], a_i[k+2], (k == 1) ? 2'd2 : 2'd0);
                {n_r[k], n_i[k], n_r[k+2], n_i[k+2]} = bf;
                bf = bfly(a_r[k+4], a_i[k+4], a_r[k+6], a_i[k+6], (k == 1) ? 2'd2 : 2'd0);
                {n_r[k+4], n_i[k+4], n_r[k+6], n_i[k+6]} = bf;
            end
            S3: for (int k = 0; k < 4; k++) begin
                bf = bfly(a_r[k], a_i[k], a_r[k+4], a_i[k+4], 2'(k));
                {n_r[k], n_i[k], n_r[k+4], n_i[k+4]} = bf;
            end
            default: ;
        endcase
    end

    // Reset in any state discards the frame in flight and clears the presented result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                a_r[k] <= '0;
                a_i[k] <= '0;
                o_r[k] <= '0;
                o_i[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int k = 0; k < 8; k++) begin
                        a_r[k] <= in_r[rev3(3'(k))];
                        a_i[k] <= in_i[rev3(3'(k))];
                    end
                    state <= S1;
                end
                S1: begin
                    a_r   <= n_r;
                    a_i   <= n_i;
                    state <= S2;
                end
                S2: begin
                    a_r   <= n_r;
                    a_i   <= n_i;
                    state <= S3;
                end
                S3: begin
                    o_r       <= n_r;
                    o_i       <= n_i;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_8_seq.sv
// Bench for ifft_8_seq: a direct-form fixed-point IFFT model feeds a scoreboard checked every output cycle,
// plus literal expectations for impulse, DC and tone frames, timing, backpressure and reset.
module tb_ifft_8_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] in_r  [8];
    logic [W-1:0] in_i  [8];
    logic [W-1:0] out_r [8];
    logic [W-1:0] out_i [8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int results = 0;
    int acc [6];
    int idx;
    int guard;

    logic [255:0] exp_q [$];
    logic [255:0] f_imp, f_dc, f_tone, f_b3, f_mix, f_ext, f_rnd;
    logic [255:0] imp_lit, dc_lit, tone_lit;
    logic [255:0] seq [6];
    logic [15:0]  tone_r [8] = '{16'h0100, 16'h00B5, 16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B, 16'h0000, 16'h00B5};
    logic [15:0]  tone_i [8] = '{16'h0000, 16'h00B5, 16'h0100, 16'h00B5, 16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B};

    ifft_8_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_0_r(in_r[0]), .in_1_r(in_r[1]), .in_2_r(in_r[2]), .in_3_r(in_r[3]),
        .in_4_r(in_r[4]), .in_5_r(in_r[5]), .in_6_r(in_r[6]), .in_7_r(in_r[7]),
        .in_0_i(in_i[0]), .in_1_i(in_i[1]), .in_2_i(in_i[2]), .in_3_i(in_i[3]),
        .in_4_i(in_i[4]), .in_5_i(in_i[5]), .in_6_i(in_i[6]), .in_7_i(in_i[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_0_r(out_r[0]), .out_1_r(out_r[1]), .out_2_r(out_r[2]), .out_3_r(out_r[3]),
        .out_4_r(out_r[4]), .out_5_r(out_r[5]), .out_6_r(out_r[6]), .out_7_r(out_r[7]),
        .out_0_i(out_i[0]), .out_1_i(out_i[1]), .out_2_i(out_i[2]), .out_3_i(out_i[3]),
        .out_4_i(out_i[4]), .out_5_i(out_i[5]), .out_6_i(out_i[6]), .out_7_i(out_i[7])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame packing: real part of sample k at [16k +: 16], imaginary part at [128 + 16k +: 16]
    function automatic logic [255:0] pack_in();
        logic [255:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p[k*16 +: 16]       = in_r[k];
            p[128 + k*16 +: 16] = in_i[k];
        end
        return p;
    endfunction

    function automatic logic [255:0] pack_out();
        logic [255:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p[k*16 +: 16]       = out_r[k];
            p[128 + k*16 +: 16] = out_i[k];
        end
        return p;
    endfunction

    function automatic int wrap16(input int v);
        logic signed [15:0] t;
        t = 16'(v);
        return int'(t);
    endfunction

    // Iterative DIT IFFT on plain integers: scale by 1/2 per stage with floor, wrap to 16 bits
    function automatic logic [255:0] ifft_model(input logic [255:0] f);
        int re [8];
        int im [8];
        int b, e, ar, ai, br, bi, tr, ti;
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            b = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
            re[k] = int'($signed(f[b*16 +: 16]));
            im[k] = int'($signed(f[128 + b*16 +: 16]));
        end
        for (int h = 1; h < 8; h = h * 2) begin
            for (int k = 0; k < 8; k++) begin
                if ((k & h) == 0) begin
                    e  = (k % h) * (4 / h);
                    ar = re[k];   ai = im[k];
                    br = re[k+h]; bi = im[k+h];
                    case (e)
                        1: begin tr = ((br - bi) * 181) >>> 8;  ti = ((br + bi) * 181) >>> 8; end
                        2: begin tr = -bi;                      ti = br;                      end
                        3: begin tr = ((-br - bi) * 181) >>> 8; ti = ((br - bi) * 181) >>> 8; end
                        default: begin tr = br; ti = bi; end
                    endcase
                    re[k]   = wrap16((ar + tr) >>> 1);
                    im[k]   = wrap16((ai + ti) >>> 1);
                    re[k+h] = wrap16((ar - tr) >>> 1);
                    im[k+h] = wrap16((ai - ti) >>> 1);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            r[k*16 +: 16]       = 16'(re[k]);
            r[128 + k*16 +: 16] = 16'(im[k]);
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [255:0] f, input logic v);
        for (int k = 0; k < 8; k++) begin
            in_r[k] = f[k*16 +: 16];
            in_i[k] = f[128 + k*16 +: 16];
        end
        in_valid = v;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push the model result on each accept, compare every cycle out_valid is high
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame: got %0h expected no frame", pack_out());
                end else begin
                    checkOutput("frame", pack_out(), exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        results++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ifft_model(pack_in()));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        f_imp = '0; f_dc = '0; f_tone = '0; f_b3 = '0; f_mix = '0; f_ext = '0;
        imp_lit = '0; dc_lit = '0; tone_lit = '0;
        f_imp[15:0]  = 16'h0800;
        f_tone[31:16] = 16'h0800;
        f_b3[63:48]   = 16'h0800;
        f_b3[128 + 80 +: 16] = 16'hFC00;
        dc_lit[15:0] = 16'h0800;
        for (int k = 0; k < 8; k++) begin
            f_dc[k*16 +: 16]          = 16'h0800;
            imp_lit[k*16 +: 16]       = 16'h0100;
            tone_lit[k*16 +: 16]      = tone_r[k];
            tone_lit[128 + k*16 +: 16] = tone_i[k];
            f_mix[k*16 +: 16]         = 16'(k * 16'h0300 - 16'h1000);
            f_mix[128 + k*16 +: 16]   = 16'(16'h0700 - k * 16'h0211);
            f_ext[k*16 +: 16]         = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
            f_ext[128 + k*16 +: 16]   = (k % 3 == 0) ? 16'h8000 : 16'h7FFF;
        end
        seq = '{f_imp, f_dc, f_tone, f_b3, f_mix, f_ext};
        applyStimulus('0, 1'b0);

        checkOutput("model_impulse", ifft_model(f_imp), imp_lit);
        checkOutput("model_dc", ifft_model(f_dc), dc_lit);
        checkOutput("model_tone", ifft_model(f_tone), tone_lit);

        // Reset state; in_ready is held low while rst is asserted
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 256'(in_ready), 256'(0));
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 256'(in_ready), 256'(1));
        checkOutput("rst_outputs", pack_out(), '0);

        // Impulse with latency, then backpressure in DONE
        @(posedge clk); #1 applyStimulus(f_imp, 1'b1);
        @(negedge clk);
        checkOutput("accept_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_e0", 256'(out_valid), 256'(0));
        @(negedge clk);
        checkOutput("lat_e1", 256'(out_valid), 256'(0));
        @(negedge clk);
        checkOutput("lat_e2", 256'(out_valid), 256'(0));
        @(negedge clk);
        checkOutput("lat_e3", 256'(out_valid), 256'(1));
        checkOutput("impulse_lit", pack_out(), imp_lit);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 8; k++) f_rnd[k*32 +: 32] = $urandom;
            applyStimulus(f_rnd, t[0]);
            @(negedge clk);
            checkOutput("bp_valid", 256'(out_valid), 256'(1));
            checkOutput("bp_in_ready", 256'(in_ready), 256'(0));
        end
        checkOutput("bp_hold_lit", pack_out(), imp_lit);
        @(posedge clk); #1 applyStimulus('0, 1'b0); out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("consume_valid", 256'(out_valid), 256'(0));
        checkOutput("consume_in_ready", 256'(in_ready), 256'(1));

        // Reset while in S2 discards the frame; a fresh impulse still yields the impulse result
        @(posedge clk); #1 applyStimulus(f_tone, 1'b1); out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid", 256'(out_valid), 256'(0));
        checkOutput("abort_outputs", pack_out(), '0);
        checkOutput("abort_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1 applyStimulus(f_imp, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int t = 0; t < 10 && !out_valid; t++) @(negedge clk);
        checkOutput("reimpulse_valid", 256'(out_valid), 256'(1));
        checkOutput("reimpulse_lit", pack_out(), imp_lit);

        // Back-to-back frames with in_valid and out_ready held high
        @(posedge clk); #1 applyStimulus(seq[0], 1'b1);
        idx = 0;
        guard = 0;
        while (idx < 6 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                acc[idx] = cyc;
                idx++;
                @(posedge clk); #1;
                if (idx < 6) applyStimulus(seq[idx], 1'b1);
                else in_valid = 1'b0;
            end
        end
        checkOutput("b2b_accepts", 256'(idx), 256'(6));
        for (int i = 1; i < 6; i++) checkOutput("b2b_spacing", 256'(acc[i] - acc[i-1]), 256'(5));
        for (int t = 0; t < 60 && (exp_q.size() != 0 || out_valid); t++) @(negedge clk);
        checkOutput("drained", 256'(exp_q.size()), 256'(0));
        checkOutput("result_count", 256'(results), 256'(8));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
